// File: rtl/dot_acc34_pkg.sv
// Shared widths, defaults and FSM encoding for the dot-product accumulator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dot_acc34_pkg;

    localparam int MULT_W      = 34;
    localparam int PROD_W      = 2 * MULT_W;
    localparam int ACC_W_DEF   = 76;
    localparam int MAX_LEN_DEF = 256;
    localparam int CNT_W       = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Beat counter increment that sticks at the limit.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic [CNT_W-1:0] lim);
        return (c >= lim) ? lim : c + 1'b1;
    endfunction

endpackage

// File: rtl/mult34.sv
// Unsigned 34x34 Karatsuba multiplier with a single output register.
// Latency: 1 cycle from operands to o_p.
// Backpressure: none; captures every cycle, caller tracks validity.
module mult34
    import dot_acc34_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [MULT_W-1:0] i_a,
    input  logic [MULT_W-1:0] i_b,
    output logic [PROD_W-1:0] o_p
);

    localparam int H = MULT_W / 2;

    logic [H-1:0]      w_ah, w_al, w_bh, w_bl;
    logic [H:0]        w_as, w_bs;
    logic [2*H-1:0]    w_hh, w_ll;
    logic [2*H+1:0]    w_mid;
    logic [PROD_W-1:0] w_cross, w_prod;
    logic [PROD_W-1:0] r_p;

    assign w_ah = i_a[MULT_W-1:H];
    assign w_al = i_a[H-1:0];
    assign w_bh = i_b[MULT_W-1:H];
    assign w_bl = i_b[H-1:0];

    assign w_as  = {1'b0, w_ah} + {1'b0, w_al};
    assign w_bs  = {1'b0, w_bh} + {1'b0, w_bl};
    assign w_hh  = {{H{1'b0}}, w_ah} * {{H{1'b0}}, w_bh};
    assign w_ll  = {{H{1'b0}}, w_al} * {{H{1'b0}}, w_bl};
    assign w_mid = {{(H+1){1'b0}}, w_as} * {{(H+1){1'b0}}, w_bs};

    // (ah+al)(bh+bl) - hh - ll is the cross term ah*bl + al*bh, never negative.
    assign w_cross = PROD_W'(w_mid) - PROD_W'(w_hh) - PROD_W'(w_ll);
    assign w_prod  = (PROD_W'(w_hh) << (2*H)) + (w_cross << H) + PROD_W'(w_ll);

    // Product register is deliberately not cleared; it just freezes while reset is held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_p <= w_prod;
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/dot_acc34.sv
// Streaming unsigned dot product of 34-bit operand pairs into an ACC_W-bit sum.
// Latency: last beat accepted at edge E -> out_valid high after edge E+1.
// Backpressure: in_ready low for the close cycle and while a result is held unaccepted.
module dot_acc34
    import dot_acc34_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MULT_W-1:0] in_a,
    input  logic [MULT_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);

    state_t            r_state, w_state_nxt;
    logic              r_v1, r_l1, r_ovf_acc;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out_valid, r_out_ovf;
    logic [ACC_W-1:0]  r_out_sum;
    logic [CNT_W-1:0]  r_out_count;

    logic [PROD_W-1:0] w_prod;
    logic              w_accept, w_close, w_in_ready, w_ovf_nxt;
    logic [ACC_W-1:0]  w_sum;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // Operands feed the multiplier directly so the product lands on the accept edge.
    mult34 u_mult (
        .clk   (clk),
        .reset (reset),
        .i_a   (in_a),
        .i_b   (in_b),
        .o_p   (w_prod)
    );

    // The close cycle (last product in flight) is the single bubble per vector.
    assign w_close    = r_v1 && r_l1;
    assign w_in_ready = !w_close && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    assign w_sum     = r_acc + ACC_W'(w_prod);
    assign w_cnt_nxt = sat_inc(r_cnt, LEN_MAX);
    assign w_ovf_nxt = r_ovf_acc || (r_cnt == LEN_MAX);

    // Vector-phase next state: IDLE -> ACCUM/FLUSH on accepts, FLUSH -> IDLE on close.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = in_last ? FLUSH : ACCUM;
            end
            ACCUM: begin
                if (w_accept && in_last) w_state_nxt = FLUSH;
            end
            FLUSH: begin
                if (w_close) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Shadow pipe tracking the multiplier stage, plus the running accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1      <= 1'b0;
            r_l1      <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
        end else begin
            r_v1 <= w_accept;
            r_l1 <= w_accept && in_last;
            if (r_v1) begin
                if (r_l1) begin
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_ovf_acc <= 1'b0;
                end else begin
                    r_acc     <= w_sum;
                    r_cnt     <= w_cnt_nxt;
                    r_ovf_acc <= w_ovf_nxt;
                end
            end
        end
    end

    // Result holding register; a close on a consuming edge reloads instead of clearing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_close) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum;
            r_out_count <= w_cnt_nxt;
            r_out_ovf   <= w_ovf_nxt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_dot_acc34.sv
// Self-checking bench for dot_acc34: directed scenarios plus randomized vectors.
// Expected results come from a queue-based arithmetic model of each vector.
// Results are collected on out_valid && out_ready and compared in order.
module tb_dot_acc34;

    localparam int AW = 76;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, in_last;
    logic [33:0]   in_a, in_b;
    logic          out_valid, out_ready, out_ovf;
    logic [AW-1:0] out_sum;
    logic [8:0]    out_count;

    int tests = 0;
    int fails = 0;

    logic [AW-1:0] exp_sum_q[$], got_sum_q[$];
    logic [8:0]    exp_cnt_q[$], got_cnt_q[$];
    logic          exp_ovf_q[$], got_ovf_q[$];
    logic [33:0]   va_q[$], vb_q[$];

    logic          prev_hold = 1'b0;
    logic [AW-1:0] prev_sum;
    logic [8:0]    prev_cnt;
    logic          prev_ovf;
    logic          rnd_ready = 1'b0;

    always #5 clk = ~clk;

    dot_acc34 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output collector and hold-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (prev_hold && out_valid) begin
            check("hold_sum",   128'(out_sum),   128'(prev_sum));
            check("hold_count", 128'(out_count), 128'(prev_cnt));
            check("hold_ovf",   128'(out_ovf),   128'(prev_ovf));
        end
        prev_hold <= out_valid && !out_ready;
        prev_sum  <= out_sum;
        prev_cnt  <= out_count;
        prev_ovf  <= out_ovf;
        if (out_valid && out_ready) begin
            got_sum_q.push_back(out_sum);
            got_cnt_q.push_back(out_count);
            got_ovf_q.push_back(out_ovf);
        end
    end

    // Reference: the dot product of the queued vector with plain wide arithmetic.
    function automatic void model_vec();
        logic [AW-1:0] s = '0;
        int n = va_q.size();
        foreach (va_q[i]) s += AW'(va_q[i]) * AW'(vb_q[i]);
        exp_sum_q.push_back(s);
        exp_cnt_q.push_back(n > 256 ? 9'd256 : 9'(n));
        exp_ovf_q.push_back(n > 256);
    endfunction

    function automatic logic [33:0] rnd34();
        logic [63:0] r = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) return '1;
        return r[33:0];
    endfunction

    // Present one beat and wait (bounded) for it to be accepted; reports stall cycles.
    task automatic drive_beat(input logic [33:0] a, input logic [33:0] b,
                              input logic last, output int stalls);
        logic took = 1'b0;
        stalls   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        for (int k = 0; k < 600 && !took; k++) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = in_ready;
            if (!took) stalls++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("accept_in_time", 128'(took), 128'(1));
    endtask

    task automatic drive_vec(input int gap_pct);
        int st;
        for (int i = 0; i < va_q.size(); i++) begin
            if ($urandom_range(0, 99) < gap_pct)
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            drive_beat(va_q[i], vb_q[i], (i == va_q.size() - 1), st);
        end
    endtask

    task automatic send_vec(input int gap_pct);
        model_vec();
        drive_vec(gap_pct);
    endtask

    // Let outstanding results come out, then compare them in order with the model.
    task automatic drain();
        out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        for (int k = 0; k < 100 && got_sum_q.size() < exp_sum_q.size(); k++) begin
            @(posedge clk); #1;
        end
        check("result_count", 128'(got_sum_q.size()), 128'(exp_sum_q.size()));
        while (exp_sum_q.size() > 0 && got_sum_q.size() > 0) begin
            check("sum",   128'(got_sum_q.pop_front()), 128'(exp_sum_q.pop_front()));
            check("count", 128'(got_cnt_q.pop_front()), 128'(exp_cnt_q.pop_front()));
            check("ovf",   128'(got_ovf_q.pop_front()), 128'(exp_ovf_q.pop_front()));
        end
        exp_sum_q.delete(); exp_cnt_q.delete(); exp_ovf_q.delete();
        got_sum_q.delete(); got_cnt_q.delete(); got_ovf_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        logic [AW-1:0] k_full;

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_sum",   128'(out_sum),   128'(0));
        check("rst_out_count", 128'(out_count), 128'(0));
        check("rst_out_ovf",   128'(out_ovf),   128'(0));
        check("rst_in_ready",  128'(in_ready),  128'(1));

        // Single beat 3*5: not valid right after the accept edge, valid one edge later.
        va_q = '{34'd3}; vb_q = '{34'd5}; model_vec();
        drive_beat(34'd3, 34'd5, 1'b1, st);
        check("lat_early_valid", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        check("lat_valid", 128'(out_valid), 128'(1));
        check("lat_sum",   128'(out_sum),   128'(15));
        check("lat_count", 128'(out_count), 128'(1));
        check("lat_ovf",   128'(out_ovf),   128'(0));
        drain();

        // Full-scale operands, four beats.
        k_full = 76'd4 * ((76'd1 << 68) - (76'd1 << 35) + 76'd1);
        exp_sum_q.push_back(k_full); exp_cnt_q.push_back(9'd4); exp_ovf_q.push_back(1'b0);
        va_q = '{'1, '1, '1, '1}; vb_q = '{'1, '1, '1, '1};
        drive_vec(0);
        drain();

        // Backpressure: result held for 5 cycles while the next beat waits.
        out_ready = 1'b0;
        va_q = '{34'd2}; vb_q = '{34'd7}; model_vec();
        drive_beat(34'd2, 34'd7, 1'b1, st);
        in_valid = 1'b1; in_a = 34'd3; in_b = 34'd4; in_last = 1'b0;
        @(posedge clk); #1;
        repeat (5) begin
            check("bp_valid",    128'(out_valid), 128'(1));
            check("bp_sum",      128'(out_sum),   128'(14));
            check("bp_count",    128'(out_count), 128'(1));
            check("bp_in_ready", 128'(in_ready),  128'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1; #1;
        check("bp_release_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive_beat(34'd5, 34'd6, 1'b1, st);
        va_q = '{34'd3, 34'd5}; vb_q = '{34'd4, 34'd6}; model_vec();
        drain();

        // Back-to-back vectors with in_valid held: one bubble after each last beat.
        va_q = '{34'd1, 34'd3}; vb_q = '{34'd2, 34'd4}; model_vec();
        va_q = '{34'd5};        vb_q = '{34'd6};        model_vec();
        va_q = '{34'd7};        vb_q = '{34'd8};        model_vec();
        drive_beat(34'd1, 34'd2, 1'b0, st);
        drive_beat(34'd3, 34'd4, 1'b1, st);
        check("b2b_stall_midvec", 128'(st), 128'(0));
        drive_beat(34'd5, 34'd6, 1'b1, st);
        check("b2b_stall_v2", 128'(st), 128'(1));
        drive_beat(34'd7, 34'd8, 1'b1, st);
        check("b2b_stall_v3", 128'(st), 128'(1));
        drain();

        // Length overflow: 257 beats, then a clean short vector.
        va_q.delete(); vb_q.delete();
        repeat (257) begin va_q.push_back(34'd1); vb_q.push_back(34'd1); end
        send_vec(0);
        va_q = '{34'd2}; vb_q = '{34'd2}; send_vec(0);
        drain();

        // Reset mid-vector discards the partial sum.
        drive_beat(34'd10, 34'd10, 1'b0, st);
        drive_beat(34'd10, 34'd10, 1'b0, st);
        drive_beat(34'd10, 34'd10, 1'b0, st);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstmid_valid",    128'(out_valid), 128'(0));
        check("rstmid_in_ready", 128'(in_ready),  128'(1));
        va_q = '{34'd4}; vb_q = '{34'd4}; send_vec(0);
        drain();

        // Reset with a result pending drops it.
        out_ready = 1'b0;
        drive_beat(34'd7, 34'd7, 1'b1, st);
        @(posedge clk); #1;
        check("rstpend_before", 128'(out_valid), 128'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstpend_valid", 128'(out_valid), 128'(0));
        check("rstpend_sum",   128'(out_sum),   128'(0));
        drain();

        // Randomized vectors with gaps and random output backpressure.
        rnd_ready = 1'b1;
        repeat (25) begin
            va_q.delete(); vb_q.delete();
            repeat ($urandom_range(1, 8)) begin
                va_q.push_back(rnd34());
                vb_q.push_back(rnd34());
            end
            send_vec(30);
        end
        rnd_ready = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
